// File: rtl/wb_scoreboard_arb.sv
`default_nettype none
// ============================================================================
//  Module      : wb_scoreboard_arb
//  Description : Register scoreboard with a two-source writeback arbiter.
//                Tracks one busy bit per architectural register, stalls
//                issue on RAW/WAW hazards, and arbitrates ALU and load-unit
//                writebacks onto a single register-file write port using
//                round-robin. A drain handshake quiesces issue until all
//                outstanding writebacks have landed.
//
//  Ports
//    clk                          : clock, all state on rising edge
//    reset                        : synchronous reset, active low
//    iss_valid/iss_req/iss_prov   : issue request, source and dest masks
//    iss_ready                    : issue accepted when high with iss_valid
//    ex_valid/ex_idx/ex_data      : ALU writeback request
//    ex_ready                     : ALU writeback granted
//    mem_valid/mem_idx/mem_data   : load writeback request
//    mem_ready                    : load writeback granted
//    wr_en/wr_idx/wr_data         : registered register-file write port
//    drain_req/drain_done         : quiesce request and acknowledge
//    busy                         : scoreboard busy bits
//    sb_err                       : sticky "write to non-busy register" flag
//
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_scoreboard_arb #(
    parameter int NREG = 16,
    parameter int DW   = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          iss_valid,
    input  logic [NREG-1:0]               iss_req,
    input  logic [NREG-1:0]               iss_prov,
    output logic                          iss_ready,
    input  logic                          ex_valid,
    input  logic [$clog2(NREG)-1:0]       ex_idx,
    input  logic [DW-1:0]                 ex_data,
    output logic                          ex_ready,
    input  logic                          mem_valid,
    input  logic [$clog2(NREG)-1:0]       mem_idx,
    input  logic [DW-1:0]                 mem_data,
    output logic                          mem_ready,
    output logic                          wr_en,
    output logic [$clog2(NREG)-1:0]       wr_idx,
    output logic [DW-1:0]                 wr_data,
    input  logic                          drain_req,
    output logic                          drain_done,
    output logic [NREG-1:0]               busy,
    output logic                          sb_err
);

    localparam int c_IW = $clog2(NREG);

    localparam logic [1:0] c_S_ACTIVE = 2'd0;
    localparam logic [1:0] c_S_DRAIN  = 2'd1;
    localparam logic [1:0] c_S_DONE   = 2'd2;

    localparam logic c_RR_EX  = 1'b0;
    localparam logic c_RR_MEM = 1'b1;

    localparam logic [NREG-1:0] c_ONE = {{(NREG-1){1'b0}}, 1'b1};

    logic [NREG-1:0] r_busy;
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_rr;
    logic            r_wr_en;
    logic [c_IW-1:0] r_wr_idx;
    logic [DW-1:0]   r_wr_data;
    logic            r_sb_err;

    logic            w_stall;
    logic            w_iss_ready;
    logic            w_accept;
    logic            w_ex_gnt;
    logic            w_mem_gnt;
    logic            w_grant;
    logic            w_contended;
    logic [c_IW-1:0] w_gnt_idx;
    logic [DW-1:0]   w_gnt_data;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_busy_nxt;

    // Hazard check uses registered busy only; a register freed this cycle
    // becomes issuable next cycle.
    assign w_stall     = |(r_busy & (iss_req | iss_prov));
    // Handshake outputs are forced low during a reset cycle so nothing is
    // accepted that reset is about to discard.
    assign w_iss_ready = reset & (r_state == c_S_ACTIVE) & ~w_stall;
    assign w_accept    = iss_valid & w_iss_ready;

    assign w_contended = ex_valid & mem_valid;
    assign w_ex_gnt    = reset & ex_valid  & (~mem_valid | (r_rr == c_RR_EX));
    assign w_mem_gnt   = reset & mem_valid & (~ex_valid  | (r_rr == c_RR_MEM));
    assign w_grant     = w_ex_gnt | w_mem_gnt;
    assign w_gnt_idx   = w_mem_gnt ? mem_idx  : ex_idx;
    assign w_gnt_data  = w_mem_gnt ? mem_data : ex_data;

    // Set wins over clear so an issue re-claiming a register being written
    // back in the same cycle keeps it busy.
    assign w_set      = w_accept ? iss_prov : '0;
    assign w_clr      = w_grant ? (c_ONE << w_gnt_idx) : '0;
    assign w_busy_nxt = (r_busy & ~w_clr) | w_set;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy    <= '0;
            r_rr      <= c_RR_EX;
            r_wr_en   <= 1'b0;
            r_wr_idx  <= '0;
            r_wr_data <= '0;
            r_sb_err  <= 1'b0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_wr_en <= w_grant;
            if (w_grant) begin
                r_wr_idx  <= w_gnt_idx;
                r_wr_data <= w_gnt_data;
                if (!r_busy[w_gnt_idx]) begin
                    r_sb_err <= 1'b1;
                end
            end
            // Pointer moves to the loser only when both sides competed.
            if (w_grant && w_contended) begin
                r_rr <= w_ex_gnt ? c_RR_MEM : c_RR_EX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_S_ACTIVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_ACTIVE: begin
                if (drain_req) begin
                    w_state_nxt = c_S_DRAIN;
                end
            end
            c_S_DRAIN: begin
                if (!drain_req) begin
                    w_state_nxt = c_S_ACTIVE;
                end else if ((w_busy_nxt == '0) && !w_grant) begin
                    // Waiting for no grant means the final write has
                    // already left the write register before DONE.
                    w_state_nxt = c_S_DONE;
                end
            end
            c_S_DONE: begin
                if (!drain_req) begin
                    w_state_nxt = c_S_ACTIVE;
                end
            end
            default: begin
                w_state_nxt = c_S_ACTIVE;
            end
        endcase
    end

    assign iss_ready  = w_iss_ready;
    assign ex_ready   = w_ex_gnt;
    assign mem_ready  = w_mem_gnt;
    assign wr_en      = r_wr_en;
    assign wr_idx     = r_wr_idx;
    assign wr_data    = r_wr_data;
    assign drain_done = (r_state == c_S_DONE);
    assign busy       = r_busy;
    assign sb_err     = r_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_scoreboard_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_scoreboard_arb
//  Description : Directed self-checking bench for wb_scoreboard_arb.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_scoreboard_arb;

    localparam int NREG = 16;
    localparam int DW   = 64;

    logic            clk;
    logic            reset;
    logic            iss_valid;
    logic [NREG-1:0] iss_req;
    logic [NREG-1:0] iss_prov;
    logic            iss_ready;
    logic            ex_valid;
    logic [3:0]      ex_idx;
    logic [DW-1:0]   ex_data;
    logic            ex_ready;
    logic            mem_valid;
    logic [3:0]      mem_idx;
    logic [DW-1:0]   mem_data;
    logic            mem_ready;
    logic            wr_en;
    logic [3:0]      wr_idx;
    logic [DW-1:0]   wr_data;
    logic            drain_req;
    logic            drain_done;
    logic [NREG-1:0] busy;
    logic            sb_err;

    int n_checks;
    int n_errors;

    wb_scoreboard_arb #(.NREG(NREG), .DW(DW)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .iss_valid  (iss_valid),
        .iss_req    (iss_req),
        .iss_prov   (iss_prov),
        .iss_ready  (iss_ready),
        .ex_valid   (ex_valid),
        .ex_idx     (ex_idx),
        .ex_data    (ex_data),
        .ex_ready   (ex_ready),
        .mem_valid  (mem_valid),
        .mem_idx    (mem_idx),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .drain_req  (drain_req),
        .drain_done (drain_done),
        .busy       (busy),
        .sb_err     (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_req = '0; iss_prov = '0;
        ex_valid  = 1'b0; ex_idx  = '0; ex_data  = '0;
        mem_valid = 1'b0; mem_idx = '0; mem_data = '0;
        drain_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        reset = 1'b0;

        // ---------------- reset behaviour ----------------
        tick();
        ex_valid = 1'b1; mem_valid = 1'b1; iss_valid = 1'b1;
        settle();
        check("rst_iss_ready", iss_ready, 1'b0);
        check("rst_ex_ready",  ex_ready,  1'b0);
        check("rst_mem_ready", mem_ready, 1'b0);
        tick();
        idle();
        reset = 1'b1;
        settle();
        check("rst_busy",    busy,    16'h0000);
        check("rst_wr_en",   wr_en,   1'b0);
        check("rst_wr_idx",  wr_idx,  4'd0);
        check("rst_wr_data", wr_data, 64'd0);
        check("rst_sb_err",  sb_err,  1'b0);
        check("rst_done",    drain_done, 1'b0);
        check("rst_iss_rdy", iss_ready,  1'b1);

        // ---------------- RAW stall on r3 ----------------
        iss_valid = 1'b1; iss_prov = 16'h0008;
        settle();
        check("raw_accept", iss_ready, 1'b1);
        tick();
        iss_prov = '0; iss_req = 16'h0008;
        settle();
        check("raw_busy",  busy,      16'h0008);
        check("raw_stall", iss_ready, 1'b0);
        tick();
        check("raw_stall2", iss_ready, 1'b0);
        check("raw_noclr",  wr_en,     1'b0);
        ex_valid = 1'b1; ex_idx = 4'd3; ex_data = 64'h0000_00A5_DEAD_BEEF;
        settle();
        check("raw_ex_gnt", ex_ready,  1'b1);
        check("raw_stall3", iss_ready, 1'b0);
        tick();
        ex_valid = 1'b0;
        settle();
        check("raw_wr_en",   wr_en,     1'b1);
        check("raw_wr_idx",  wr_idx,    4'd3);
        check("raw_wr_data", wr_data,   64'h0000_00A5_DEAD_BEEF);
        check("raw_busy0",   busy,      16'h0000);
        check("raw_ready",   iss_ready, 1'b1);
        check("raw_sb_err",  sb_err,    1'b0);
        tick();
        idle();
        settle();
        check("raw_wr_off",  wr_en,   1'b0);
        check("raw_hold",    wr_idx,  4'd3);

        // ---------------- round robin from reset ----------------
        do_reset();
        ex_valid = 1'b1; mem_valid = 1'b1; ex_idx = 4'd1; mem_idx = 4'd2;
        for (int i = 0; i < 4; i++) begin
            ex_data  = 64'h100 + 64'(i);
            mem_data = 64'h200 + 64'(i);
            settle();
            check("rr_ex_ready",  ex_ready,  (i % 2 == 0) ? 1'b1 : 1'b0);
            check("rr_mem_ready", mem_ready, (i % 2 == 0) ? 1'b0 : 1'b1);
            tick();
            check("rr_wr_en",   wr_en,  1'b1);
            check("rr_wr_idx",  wr_idx, (i % 2 == 0) ? 4'd1 : 4'd2);
            check("rr_wr_data", wr_data,
                  (i % 2 == 0) ? (64'h100 + 64'(i)) : (64'h200 + 64'(i)));
        end
        // Uncontended MEM grant must leave the pointer on EX.
        ex_valid = 1'b0;
        settle();
        check("rr_solo_mem", mem_ready, 1'b1);
        check("rr_solo_ex",  ex_ready,  1'b0);
        tick();
        ex_valid = 1'b1;
        settle();
        check("rr_keep_ex",  ex_ready,  1'b1);
        check("rr_keep_mem", mem_ready, 1'b0);
        check("rr_sb_err",   sb_err,    1'b1);
        tick();
        idle();

        // ---------------- reset mid-operation ----------------
        iss_valid = 1'b1; iss_prov = 16'hFFFF;
        tick();
        idle();
        settle();
        check("mid_busy_full", busy, 16'hFFFF);
        reset = 1'b0;
        ex_valid = 1'b1; ex_idx = 4'd2; ex_data = 64'h77;
        settle();
        check("mid_ex_ready", ex_ready, 1'b0);
        tick();
        reset = 1'b1;
        idle();
        settle();
        check("mid_busy",   busy,   16'h0000);
        check("mid_wr_en",  wr_en,  1'b0);
        check("mid_sb_err", sb_err, 1'b0);

        // ---------------- WAW stall while r5 writes back ----------------
        iss_valid = 1'b1; iss_prov = 16'h0020;
        tick();
        settle();
        check("waw_busy5", busy, 16'h0020);
        ex_valid = 1'b1; ex_idx = 4'd5; ex_data = 64'h55;
        settle();
        check("waw_stall", iss_ready, 1'b0);
        check("waw_gnt",   ex_ready,  1'b1);
        tick();
        ex_valid = 1'b0;
        settle();
        check("waw_busy0",  busy,      16'h0000);
        check("waw_wr_idx", wr_idx,    4'd5);
        check("waw_ready",  iss_ready, 1'b1);
        tick();
        iss_valid = 1'b0; iss_prov = '0;
        settle();
        check("waw_busy_set", busy,   16'h0020);
        check("waw_sb_err",   sb_err, 1'b0);

        // ---------------- write to non-busy r9 ----------------
        mem_valid = 1'b1; mem_idx = 4'd9; mem_data = 64'h99;
        settle();
        check("err_gnt", mem_ready, 1'b1);
        tick();
        mem_valid = 1'b0;
        settle();
        check("err_wr_en",  wr_en,  1'b1);
        check("err_wr_idx", wr_idx, 4'd9);
        check("err_sb_err", sb_err, 1'b1);
        check("err_busy",   busy,   16'h0020);
        tick(); tick();
        check("err_sticky", sb_err, 1'b1);

        // Set and clear of r6 in one cycle: set wins.
        iss_valid = 1'b1; iss_prov = 16'h0040;
        ex_valid  = 1'b1; ex_idx = 4'd6; ex_data = 64'h66;
        settle();
        check("sc_accept", iss_ready, 1'b1);
        tick();
        idle();
        settle();
        check("sc_busy", busy, 16'h0060);

        // ---------------- drain ----------------
        do_reset();
        iss_valid = 1'b1; iss_prov = 16'h0003; drain_req = 1'b1;
        settle();
        check("dr_accept", iss_ready, 1'b1);
        tick();
        iss_valid = 1'b0; iss_prov = '0;
        settle();
        check("dr_busy",      busy,       16'h0003);
        check("dr_no_issue",  iss_ready,  1'b0);
        check("dr_not_done",  drain_done, 1'b0);
        ex_valid  = 1'b1; ex_idx  = 4'd0; ex_data  = 64'hA0;
        mem_valid = 1'b1; mem_idx = 4'd1; mem_data = 64'hB1;
        settle();
        check("dr_ex_gnt", ex_ready, 1'b1);
        tick();
        ex_valid = 1'b0;
        settle();
        check("dr_busy1",    busy,      16'h0002);
        check("dr_mem_gnt",  mem_ready, 1'b1);
        tick();
        mem_valid = 1'b0;
        settle();
        check("dr_busy_clr", busy,       16'h0000);
        check("dr_wr_idx",   wr_idx,     4'd1);
        check("dr_wait",     drain_done, 1'b0);
        tick();
        check("dr_done",     drain_done, 1'b1);
        check("dr_done_iss", iss_ready,  1'b0);
        drain_req = 1'b0;
        tick();
        check("dr_exit_done", drain_done, 1'b0);
        check("dr_exit_iss",  iss_ready,  1'b1);

        // Drain abandoned before completion returns to ACTIVE.
        iss_valid = 1'b1; iss_prov = 16'h0001;
        tick();
        iss_valid = 1'b0; iss_prov = '0; drain_req = 1'b1;
        tick();
        settle();
        check("ab_draining", iss_ready, 1'b0);
        drain_req = 1'b0;
        tick();
        check("ab_active", iss_ready,  1'b1);
        check("ab_done",   drain_done, 1'b0);
        check("ab_busy",   busy,       16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
